// File: rtl/tick_sequencer_if.sv
// rtl/tick_sequencer_if.sv - start/handshake/status bundle between tick_sequencer and its consumer
//
// Purpose: groups every non-clock, non-reset signal of tick_sequencer.
// Signals:
//   start        level request to run one sequence (sampled in IDLE only)
//   ack          consumer acknowledge, four-phase
//   dut_reset_l  consumer reset, active low
//   req          per-tick request to the consumer
//   count        completed transactions
//   busy         sequence in progress (HOLD, REQ, ACK_LOW)
//   done         sticky, all transactions complete
//   timeout_err  sticky, handshake stalled
// Modports:
//   master  the sequencer (drives req and status, receives start and ack)
//   slave   the stimulus/consumer side
interface tick_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic             ack;
   logic             dut_reset_l;
   logic             req;
   logic [CNT_W-1:0] count;
   logic             busy;
   logic             done;
   logic             timeout_err;

   modport master (
      input  start,
      input  ack,
      output dut_reset_l,
      output req,
      output count,
      output busy,
      output done,
      output timeout_err
   );

   modport slave (
      output start,
      output ack,
      input  dut_reset_l,
      input  req,
      input  count,
      input  busy,
      input  done,
      input  timeout_err
   );
endinterface

// File: rtl/tick_sequencer.sv
// rtl/tick_sequencer.sv - bounded reset-hold and four-phase req/ack stimulus controller
//
// Purpose: after start, holds the consumer in reset for HOLD_CYCLES edges,
// releases it, then runs TARGET four-phase req/ack transactions. Ends in
// DONE (sticky done) or, if any single ack edge takes TIMEOUT edges, in ERR
// (sticky timeout_err). Both end states are left only through reset.
// Ports:
//   clk    single clock, all state on posedge
//   reset  asynchronous, active-high; clears every output and timer
//   bus    tick_sequencer_if.master (start, ack in; dut_reset_l, req,
//          count, busy, done, timeout_err out, all registered)
module tick_sequencer #(
   parameter int HOLD_CYCLES = 4,
   parameter int TARGET      = 25,
   parameter int CNT_W       = 8,
   parameter int TIMEOUT     = 16
) (
   input  logic               clk,
   input  logic               reset,
   tick_sequencer_if.master   bus
);

   // One timer width covers both the hold phase and the handshake waits.
   localparam int MAX_TMR = (HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT;
   localparam int TMR_W   = $clog2(MAX_TMR + 1);

   localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TGT       = CNT_W'(TARGET);

   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("tick_sequencer: HOLD_CYCLES must be at least 1");
   end
   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("tick_sequencer: TIMEOUT must be at least 2");
   end
   if (TARGET < 0 || TARGET >= (1 << CNT_W)) begin : g_bad_target
      $error("tick_sequencer: TARGET must fit in CNT_W bits");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOLD,
      S_REQ,
      S_ACK_LOW,
      S_DONE,
      S_ERR
   } state_t;

   state_t           state;
   logic [TMR_W-1:0] hold_tmr;
   logic [TMR_W-1:0] wait_tmr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= S_IDLE;
         hold_tmr        <= '0;
         wait_tmr        <= '0;
         bus.dut_reset_l <= 1'b0;
         bus.req         <= 1'b0;
         bus.count       <= '0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.timeout_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state    <= S_HOLD;
                  hold_tmr <= '0;
                  bus.busy <= 1'b1;
               end
            end

            // Hold timer value k-1 at the k-th edge after start, so the
            // release lands exactly HOLD_CYCLES edges after the start edge.
            S_HOLD: begin
               if (hold_tmr == HOLD_LAST) begin
                  bus.dut_reset_l <= 1'b1;
                  wait_tmr        <= '0;
                  if (TARGET == 0) begin
                     state    <= S_DONE;
                     bus.done <= 1'b1;
                     bus.busy <= 1'b0;
                  end else begin
                     state   <= S_REQ;
                     bus.req <= 1'b1;
                  end
               end else begin
                  hold_tmr <= hold_tmr + TMR_W'(1);
               end
            end

            // The exit condition is tested before the timeout, so an ack
            // arriving on the TIMEOUT-th edge still completes normally.
            S_REQ: begin
               if (bus.ack) begin
                  state     <= S_ACK_LOW;
                  bus.req   <= 1'b0;
                  bus.count <= bus.count + CNT_W'(1);
                  wait_tmr  <= '0;
               end else if (wait_tmr == TO_LAST) begin
                  state           <= S_ERR;
                  bus.req         <= 1'b0;
                  bus.busy        <= 1'b0;
                  bus.timeout_err <= 1'b1;
               end else begin
                  wait_tmr <= wait_tmr + TMR_W'(1);
               end
            end

            // count was already bumped on the ack-high edge, so comparing
            // against TARGET here ends the run after the last release.
            S_ACK_LOW: begin
               if (!bus.ack) begin
                  wait_tmr <= '0;
                  if (bus.count == TGT) begin
                     state    <= S_DONE;
                     bus.done <= 1'b1;
                     bus.busy <= 1'b0;
                  end else begin
                     state   <= S_REQ;
                     bus.req <= 1'b1;
                  end
               end else if (wait_tmr == TO_LAST) begin
                  state           <= S_ERR;
                  bus.busy        <= 1'b0;
                  bus.timeout_err <= 1'b1;
               end else begin
                  wait_tmr <= wait_tmr + TMR_W'(1);
               end
            end

            // Terminal states: outputs were set on entry and stay frozen.
            S_DONE: begin
               state <= S_DONE;
            end

            S_ERR: begin
               state <= S_ERR;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/tick_sequencer.md
Name: tick_sequencer

Overview:
- Upstream stimulus stage for a clocked consumer block. The consumer is held in active-low reset, acknowledges per-tick requests, and counts completed ticks.
- After `start`, this block:
  - holds the consumer in reset for a fixed number of cycles, then releases it;
  - issues TARGET four-phase req/ack transactions;
  - flags `done`, or flags `timeout_err` if the consumer stalls.
- Replaces ad-hoc busy-wait loops in bench and top-level logic with a bounded, lint-clean handshake controller.

Parameters:
- HOLD_CYCLES, 4, cycles `dut_reset_l` is held low after `start` (≥1).
- TARGET, 25, number of req/ack transactions before `done` (0 allowed).
- CNT_W, 8, width of `count`; must satisfy 2^CNT_W > TARGET.
- TIMEOUT, 16, maximum cycles spent waiting on any single ack edge (≥2).

Ports:
- clk  input  1  single clock, all state on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level, sampled only in IDLE.
- ack  input  1  consumer acknowledge, four-phase.
- dut_reset_l  output  1  consumer reset, active low, registered.
- req  output  1  request to consumer, registered.
- count  output  CNT_W  completed transactions.
- busy  output  1  high in HOLD, REQ, ACK_LOW.
- done  output  1  sticky, TARGET transactions complete.
- timeout_err  output  1  sticky, handshake stalled.

Behaviour:
- Clocking and reset (already decided): one clock `clk`. `reset` is asynchronous and active-high. On `reset` all outputs clear immediately: `dut_reset_l`=0, `req`=0, `count`=0, `busy`=0, `done`=0, `timeout_err`=0, state=IDLE. Internal timers clear to 0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, HOLD, REQ, ACK_LOW, DONE, ERR.
- IDLE:
  - `dut_reset_l`=0, `req`=0.
  - `start`=1 at edge E0 → HOLD, hold timer loads 0.
- HOLD:
  - `dut_reset_l` stays 0; hold timer increments each edge.
  - At edge E0+HOLD_CYCLES: `dut_reset_l`←1, then:
    - TARGET=0 → DONE;
    - otherwise → REQ with `req`←1 on the same edge.
- REQ:
  - `req`=1; wait timer increments each edge.
  - On an edge where `ack`=1: `req`←0, `count`←`count`+1, → ACK_LOW, wait timer←0.
- ACK_LOW:
  - `req`=0; wait timer increments each edge.
  - On an edge where `ack`=0:
    - `count`==TARGET → DONE;
    - otherwise `req`←1, → REQ, wait timer←0.
- Minimum transaction period is 2 cycles (ack toggled combinationally by the consumer). With a one-register consumer (`ack`←`req`), the period is 4 cycles.
- Timeout: if the REQ or ACK_LOW exit condition is not met at the TIMEOUT-th edge after state entry, go to ERR at that edge. ERR sets `req`←0, `timeout_err`←1, `busy`←0; `dut_reset_l` stays 1.
- DONE: `done`=1, `req`=0, `dut_reset_l`=1, `busy`=0. Sticky until `reset`; `start` ignored.
- ERR: sticky until `reset`; `start` and `ack` ignored; `count` frozen.
- `start` outside IDLE is ignored.
- `ack` high already in IDLE/HOLD: no effect; it is sampled only in REQ/ACK_LOW. If `ack` is still high on REQ entry, the first REQ edge completes the transaction.
- `count` never exceeds TARGET and never wraps (guaranteed by the CNT_W constraint).
- Reset asserted mid-operation, including mid-handshake: immediate return to reset values. `dut_reset_l` drops asynchronously; no partial count is retained.
- No `while`/unbounded loops in RTL. Every wait is bounded by TIMEOUT.

Test Plan:
- Default params, one-register responder, `start` pulse sampled at edge 0 → `dut_reset_l` and `req` rise after edge 4; `count`=1 after edge 6; `done`=1 after edge 104 with `count`=25; `timeout_err`=0 throughout.
- TARGET=0, HOLD_CYCLES=2, `start` at edge 0 → `dut_reset_l`=1 and `done`=1 after edge 2; `req` never asserts; `count`=0.
- `ack` tied 0, default params → `req`=1 from edge 4; ERR after edge 20 with `timeout_err`=1, `req`=0, `count`=0, `done`=0; re-pulsing `start` has no effect.
- `ack` stuck 1 after first transaction → `count`=1, ACK_LOW times out 16 cycles after entry, `timeout_err`=1, `count` stays 1.
- Async `reset` pulse between clock edges while `count`=10 and `req`=1 → outputs clear before the next edge (`dut_reset_l`=0, `count`=0). A fresh `start` reproduces the scenario-1 timing exactly.
- `start` held high continuously plus pulses during REQ and DONE → exactly one sequence runs; `done` after 25 transactions; no restart observed.
